// File: rtl/mem_arb_pkg.sv
// Shared constants and enums for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0033;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef enum logic [1:0] {G_NONE, G_DATA, G_FETCH} grant_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small FIFO of {pc, inst} words feeding IF; head is readable without a pop.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign pop_ok    = pop && !empty && !flush;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok   = push && !flush && (!full || pop_ok);
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction prefetch and MEM-stage data
// accesses; data wins except for a periodic forced fetch against starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  input  logic              if_pop,
  input  logic              if_redirect,
  input  logic [31:0]       if_redirect_pc,
  input  logic              halt,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  state_t            state_reg;
  grant_t            grant;
  logic [ADDR_W-1:0] fetch_ptr_reg;
  logic [ADDR_W-1:0] redirect_addr;
  logic [SC_W-1:0]   starve_cnt_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [63:0]       fifo_head;
  logic              fetch_run;
  logic              starving;

  assign fetch_run     = (state_reg == RUN);
  assign starving      = (starve_cnt_reg == SC_W'(STARVE_MAX));
  assign redirect_addr = if_redirect_pc[ADDR_W-1:0] & ~ADDR_W'(3);

  if (ADDR_W < 32) begin : g_pc_trunc
    logic unused_pc_bits;
    assign unused_pc_bits = ^if_redirect_pc[31:ADDR_W];
  end

  // Forced fetch may fire during a redirect; its word is then discarded.
  always_comb begin
    grant = G_NONE;
    if (rst)                                              grant = G_NONE;
    else if (starving && !fifo_full && fetch_run)         grant = G_FETCH;
    else if (d_req)                                       grant = G_DATA;
    else if (!fifo_full && fetch_run && !if_redirect)     grant = G_FETCH;
  end

  assign d_ready   = (grant == G_DATA);
  assign mem_read  = (grant == G_FETCH) || ((grant == G_DATA) && !d_we);
  assign mem_write = (grant == G_DATA) && d_we;
  assign mem_func3 = (grant == G_FETCH) ? FUNC3_LW :
                     (grant == G_DATA)  ? d_func3  : 3'b000;
  assign mem_addr  = (grant == G_FETCH) ? fetch_ptr_reg :
                     (grant == G_DATA)  ? d_addr        : '0;
  assign mem_wdata = (grant == G_DATA) ? d_wdata : 32'd0;

  assign fifo_push = (grant == G_FETCH) && !if_redirect;
  assign fifo_pop  = if_pop && !if_redirect;

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({32'(fetch_ptr_reg), mem_rdata}),
    .pop       (fifo_pop),
    .flush     (if_redirect),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign if_valid = !fifo_empty;
  assign if_inst  = fifo_empty ? NOP_INST : fifo_head[31:0];
  assign if_pc    = fifo_empty ? 32'd0    : fifo_head[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_reg <= RUN;
        RUN:     if (halt)  state_reg <= HALT;
        HALT:    if (!halt) state_reg <= RUN;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr_reg  <= ADDR_W'(RESET_PC);
      starve_cnt_reg <= '0;
      d_rvalid       <= 1'b0;
      d_rdata        <= 32'd0;
    end else begin
      if (if_redirect)
        fetch_ptr_reg <= redirect_addr;
      else if (grant == G_FETCH)
        fetch_ptr_reg <= fetch_ptr_reg + ADDR_W'(4);

      if (grant == G_FETCH)
        starve_cnt_reg <= '0;
      else if ((grant == G_DATA) && fifo_empty && !starving)
        starve_cnt_reg <= starve_cnt_reg + SC_W'(1);

      d_rvalid <= (grant == G_DATA) && !d_we;
      if ((grant == G_DATA) && !d_we) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench: a queue-based reference model predicts each
// cycle's port activity and load data; a monitor compares against the DUT.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_pop = 1'b0;
  logic        if_redirect = 1'b0;
  logic [31:0] if_redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_func3 = 3'b010;
  logic [7:0]  d_addr = 8'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pop(if_pop),
    .if_redirect(if_redirect), .if_redirect_pc(if_redirect_pc), .halt(halt),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, write at the clock edge.
  logic [31:0] seed_mem [64];
  logic [31:0] env_mem  [64];
  logic        preload = 1'b1;
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= seed_mem[i];
    end else if (mem_write) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          chk_regs;
    bit          rdata_zero;
    bit          d_ready;
    bit          mem_read;
    bit          mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    bit          if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    bit          d_rvalid;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] load_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nloads = 0;

  // Reference model state
  logic [31:0] ref_mem [64];
  logic [31:0] m_pc_q[$];
  logic [31:0] m_inst_q[$];
  logic [7:0]  m_fptr = 8'd0;
  int          m_cyc = 0;
  int          m_starve = 0;
  bit          m_prev_halt = 1'b0;
  bit          m_rvalid = 1'b0;

  // Stimulus for the next step
  bit          s_rst = 1'b1, s_pop = 1'b0, s_redir = 1'b0, s_halt = 1'b0;
  bit          s_dreq = 1'b0, s_dwe = 1'b0, s_chk = 1'b0;
  logic [31:0] s_rpc = 32'd0, s_dwd = 32'd0;
  logic [7:0]  s_daddr = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t        e;
    bit          full, empty, run, g_fetch, g_data;
    logic [31:0] fw;
    @(negedge clk);
    rst            = s_rst;
    if_pop         = s_pop;
    if_redirect    = s_redir;
    if_redirect_pc = s_rpc;
    halt           = s_halt;
    d_req          = s_dreq;
    d_we           = s_dwe;
    d_func3        = s_dwe ? FUNC3_SW : FUNC3_LW;
    d_addr         = s_daddr;
    d_wdata        = s_dwd;

    full    = (m_pc_q.size() == DEPTH);
    empty   = (m_pc_q.size() == 0);
    // Fetching is allowed from the second cycle after reset unless halt was high last cycle.
    run     = (m_cyc >= 1) && (m_cyc == 1 || !m_prev_halt);
    g_fetch = 1'b0;
    g_data  = 1'b0;
    if (!s_rst) begin
      if (m_starve == STARVE_MAX && !full && run) g_fetch = 1'b1;
      else if (s_dreq)                            g_data  = 1'b1;
      else if (!full && run && !s_redir)          g_fetch = 1'b1;
    end

    e.chk_regs   = s_chk;
    e.rdata_zero = (m_cyc == 0);
    e.d_ready    = g_data;
    e.mem_read   = g_fetch || (g_data && !s_dwe);
    e.mem_write  = g_data && s_dwe;
    e.mem_addr   = g_fetch ? m_fptr : s_daddr;
    e.mem_wdata  = s_dwd;
    e.if_valid   = !empty;
    e.if_pc      = empty ? 32'd0 : m_pc_q[0];
    e.if_inst    = empty ? NOP_INST : m_inst_q[0];
    e.d_rvalid   = m_rvalid;
    exp_q.push_back(e);

    if (s_rst) begin
      m_pc_q.delete();
      m_inst_q.delete();
      m_fptr   = 8'd0;
      m_cyc    = 0;
      m_starve = 0;
      m_rvalid = 1'b0;
    end else begin
      fw       = ref_mem[m_fptr[7:2]];
      m_rvalid = g_data && !s_dwe;
      if (g_data) begin
        if (s_dwe) ref_mem[s_daddr[7:2]] = s_dwd;
        else       load_q.push_back(ref_mem[s_daddr[7:2]]);
        if (empty && m_starve < STARVE_MAX) m_starve++;
      end
      if (g_fetch) m_starve = 0;
      if (s_redir) begin
        m_pc_q.delete();
        m_inst_q.delete();
        m_fptr = s_rpc[7:0] & 8'hFC;
      end else begin
        if (s_pop && !empty) begin
          void'(m_pc_q.pop_front());
          void'(m_inst_q.pop_front());
        end
        if (g_fetch) begin
          m_pc_q.push_back({24'd0, m_fptr});
          m_inst_q.push_back(fw);
          m_fptr = m_fptr + 8'd4;
        end
      end
      if (m_cyc < 1000) m_cyc++;
      m_prev_halt = s_halt;
    end
  endtask

  // Monitor: compares DUT outputs with the queued expectations each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("d_ready",   32'(d_ready),   32'(e.d_ready));
        chk("mem_read",  32'(mem_read),  32'(e.mem_read));
        chk("mem_write", 32'(mem_write), 32'(e.mem_write));
        if (e.mem_read || e.mem_write) begin
          chk("mem_addr",  32'(mem_addr),  32'(e.mem_addr));
          chk("mem_func3", 32'(mem_func3), 32'(FUNC3_LW));
        end
        if (e.mem_write) chk("mem_wdata", mem_wdata, e.mem_wdata);
        if (e.chk_regs) begin
          chk("if_valid", 32'(if_valid), 32'(e.if_valid));
          chk("if_pc",    if_pc,         e.if_pc);
          chk("if_inst",  if_inst,       e.if_inst);
          chk("d_rvalid", 32'(d_rvalid), 32'(e.d_rvalid));
          if (e.rdata_zero) chk("d_rdata_reset", d_rdata, 32'd0);
          if (d_rvalid) begin
            if (load_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL load_q actual=rvalid expected=no_pending_load t=%0t", $time);
            end else begin
              nloads++;
              $display("load %0d data=%h", nloads, d_rdata);
              chk("d_rdata", d_rdata, load_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end
    // Reset, then let the FIFO fill with nobody popping.
    s_rst = 1'b1; s_chk = 1'b0;
    step();
    preload = 1'b0;
    s_chk = 1'b1;
    step();
    s_rst = 1'b0;
    repeat (6) step();
    // Pop every cycle long enough for the fetch pointer to wrap.
    s_pop = 1'b1;
    repeat (80) step();
    // Redirect then a load at 0x40 while fetching.
    s_redir = 1'b1; s_rpc = 32'h0000_0010; s_pop = 1'b0;
    step();
    s_redir = 1'b0; s_pop = 1'b1;
    s_dreq = 1'b1; s_dwe = 1'b0; s_daddr = 8'h40;
    step();
    s_dreq = 1'b0;
    repeat (3) step();
    // Empty FIFO with data held: starvation limit forces one fetch.
    s_pop = 1'b0; s_redir = 1'b1; s_rpc = 32'h0000_0080;
    step();
    s_redir = 1'b0; s_dreq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_daddr = 8'($urandom_range(0, 63)) << 2;
      step();
    end
    s_dreq = 1'b0;
    repeat (4) step();
    // Redirect to 0x23 with a full FIFO and a same-cycle store.
    s_redir = 1'b1; s_rpc = 32'h0000_0023;
    s_dreq = 1'b1; s_dwe = 1'b1; s_daddr = 8'h80; s_dwd = $urandom;
    step();
    s_redir = 1'b0; s_dreq = 1'b0; s_dwe = 1'b0;
    repeat (3) step();
    // Load from the stored word, then halt with popping.
    s_dreq = 1'b1; s_daddr = 8'h80;
    step();
    s_dreq = 1'b0; s_pop = 1'b1; s_halt = 1'b1;
    repeat (5) step();
    s_halt = 1'b0;
    repeat (3) step();
    // Reset in the cycle after a load grant.
    s_dreq = 1'b1; s_daddr = 8'h44;
    step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0; s_dreq = 1'b0;
    repeat (4) step();
    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_redir = ($urandom_range(0, 15) == 0);
      s_rpc   = $urandom;
      if ($urandom_range(0, 19) == 0) s_halt = !s_halt;
      s_dreq  = ($urandom_range(0, 4) < 2);
      s_dwe   = $urandom_range(0, 1) == 1;
      s_daddr = 8'($urandom_range(0, 63)) << 2;
      s_dwd   = $urandom;
      s_pop   = ($urandom_range(0, 4) < 3);
      step();
    end
    s_rst = 1'b0; s_redir = 1'b0; s_dreq = 1'b0; s_halt = 1'b0; s_pop = 1'b0;
    repeat (4) step();
    @(negedge clk);
    #5;
    chk("load_q_drain", 32'(load_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
